scan_mux: RTL and testbench
===========================

// Module: scan_mux
// PURPOSE
//   Time-multiplexed N:1 selector that drives the stopwatch's multiplexed seven-segment display.
//   - Cycles through CHANNELS input words of WIDTH bits, one at a time.
//   - Presents the selected word on out and asserts a one-hot digit enable.
//   - Holds each channel for DIVIDE clocks, with a guard gap at every switch to prevent ghosting.
//   - Sits between the BCD time counters and the segment decoder.
// PARAMETERS
//   WIDTH          4      bits per channel word
//   CHANNELS       4      number of channels; any value >= 2, need not be a power of 2
//   DIVIDE         50000  clocks each channel is held (dwell); must be >= 2
//   GUARD          1      clocks at the start of each dwell with all digit enables off; 1 <= GUARD < DIVIDE
//   ACTIVE_LOW_EN  1      1: digit_en active-low (inactive = all ones); 0: active-high
// PORTS
//   clk       in   1                 system clock; all state changes on the rising edge
//   reset     in   1                 synchronous, active-high reset
//   enable    in   1                 1 = scan runs; 0 = scan frozen and display dark
//   in        in   CHANNELS*WIDTH    channel words; channel i = in[i*WIDTH +: WIDTH]
//   blank     in   CHANNELS          blank[i]=1 suppresses the digit enable for channel i only
//   out       out  WIDTH             registered word of the current channel
//   sel       out  $clog2(CHANNELS)  registered index of the current channel
//   digit_en  out  CHANNELS          registered one-hot digit enable (polarity per ACTIVE_LOW_EN)
// BEHAVIOUR
//   - Internal state:
//       tick: 0..DIVIDE-1
//       idx:  0..CHANNELS-1
//   - Reset (sampled at the edge, overrides everything):
//       tick=0, idx=0, out=0, sel=0, digit_en=all inactive.
//       Reset mid-scan gives these values from the next cycle, regardless of enable.
//   - Per edge, enable=1:
//       tick==DIVIDE-1: tick<=0 and idx<=idx+1, with CHANNELS-1 wrapping to 0.
//       Otherwise: tick<=tick+1.
//   - Per edge, enable=0: tick and idx hold.
//       On re-enable, the scan resumes at the held tick; no new guard is inserted.
//   - Outputs are registered from the pre-edge idx/tick (1-cycle latency):
//       out      <= in[idx*WIDTH +: WIDTH] every cycle, so live data changes appear 1 cycle later.
//       sel      <= idx
//       digit_en <= one-hot(idx) if enable && !blank[idx] && tick>=GUARD; else all inactive.
//   - When enable=0: out and sel keep updating from the held idx; digit_en is all inactive.
//   - Channel switch: the first GUARD registered cycles of each dwell show the new out/sel with digit_en inactive.
//       No cycle ever shows a channel's enable alongside another channel's word.
//   - Dwell per channel is exactly DIVIDE cycles:
//       GUARD cycles dark, then DIVIDE-GUARD cycles lit.
//       The scan period is CHANNELS*DIVIDE cycles.
//   - No combinational path from any input to any output.
// TESTING  (CHANNELS=4, WIDTH=4, DIVIDE=4, GUARD=1, ACTIVE_LOW_EN=1 unless stated)
//   1. Basic scan:
//        Stimulus: in=16'h4321, blank=0, enable=1, reset released.
//        Response: out sequence 1,2,3,4,1, each for 4 cycles.
//        digit_en 1111 for 1 cycle, then 1110/1101/1011/0111 for 3 cycles per channel.
//   2. Non-power-of-2 wrap:
//        Stimulus: CHANNELS=3, in=12'h321.
//        Response: sel 0,1,2,0; out 1,2,3,1; sel never equals 3.
//   3. Blanking:
//        Stimulus: blank=4'b0100.
//        Response: during channel 2, out=3 and sel=2 while digit_en stays 1111; other channels unaffected.
//   4. Enable freeze:
//        Stimulus: drop enable at tick=2 of channel 1 for 10 cycles, then raise it.
//        Response: from the next cycle sel=1, out=2, digit_en=1111.
//        After re-enable: 1101 for 1 cycle, then channel 2 (with its guard cycle).
//   5. Reset mid-scan:
//        Stimulus: assert reset for 1 cycle while sel=2.
//        Response: next cycle sel=0, out=0, digit_en=1111; the scan restarts from channel 0.
//   6. Live update / polarity:
//        Stimulus: change in[3:0] from 1 to 9 during a lit channel-0 cycle.
//        Response: out=9 on the following cycle.
//        With ACTIVE_LOW_EN=0, repeat test 1: expect 0000 then 0001/0010/0100/1000.

Source files
------------

// File: rtl/scan_if.sv
// Handshake-free bus between the scan multiplexer and its client:
// channel words and controls in, registered word/index/digit enables out.
interface scan_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int SW = $clog2(CHANNELS);

  logic                      enable;
  logic [CHANNELS*WIDTH-1:0] in;
  logic [CHANNELS-1:0]       blank;
  logic [WIDTH-1:0]          out;
  logic [SW-1:0]             sel;
  logic [CHANNELS-1:0]       digit_en;

  modport master (
    output enable, in, blank,
    input  out, sel, digit_en
  );

  modport slave (
    input  enable, in, blank,
    output out, sel, digit_en
  );
endinterface

// File: rtl/scan_mux.sv
// Time-multiplexed N:1 display scanner with per-channel dwell,
// a dark guard gap at each switch, blanking and freeze.
module scan_mux #(
  parameter int WIDTH         = 4,
  parameter int CHANNELS      = 4,
  parameter int DIVIDE        = 50000,
  parameter int GUARD         = 1,
  parameter int ACTIVE_LOW_EN = 1
) (
  input logic   clk,
  input logic   reset,
  scan_if.slave bus
);
  localparam int SW = $clog2(CHANNELS);
  localparam int TW = $clog2(DIVIDE);
  localparam logic [CHANNELS-1:0] OFF =
    (ACTIVE_LOW_EN != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

  logic [TW-1:0]       tick, tick_nxt;
  logic [SW-1:0]       idx, idx_nxt;
  logic [WIDTH-1:0]    word;
  logic [CHANNELS-1:0] onehot, en_nxt;
  logic                lit;

  always_comb begin
    tick_nxt = tick;
    idx_nxt  = idx;
    if (bus.enable) begin
      if (tick == TW'(DIVIDE - 1)) begin
        tick_nxt = '0;
        idx_nxt  = (idx == SW'(CHANNELS - 1)) ? '0 : idx + 1'b1;
      end else begin
        tick_nxt = tick + 1'b1;
      end
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx == SW'(i)) word = bus.in[i*WIDTH +: WIDTH];
    end
  end

  // XOR with the inactive pattern applies the enable polarity.
  always_comb begin
    onehot = CHANNELS'(1) << idx;
    lit    = bus.enable && !(|(bus.blank & onehot))
             && (tick >= TW'(GUARD));
    en_nxt = lit ? (onehot ^ OFF) : OFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick         <= '0;
      idx          <= '0;
      bus.out      <= '0;
      bus.sel      <= '0;
      bus.digit_en <= OFF;
    end else begin
      tick         <= tick_nxt;
      idx          <= idx_nxt;
      bus.out      <= word;
      bus.sel      <= idx;
      bus.digit_en <= en_nxt;
    end
  end
endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: 4-channel active-low, 3-channel wrap,
// and 4-channel active-high instances, all with a 4-clock dwell.
module tb_scan_mux;
  logic clk;
  logic r0, r1, r2;
  int   vectors;
  int   miscompares;

  scan_if #(.WIDTH(4), .CHANNELS(4)) i0 ();
  scan_if #(.WIDTH(4), .CHANNELS(3)) i1 ();
  scan_if #(.WIDTH(4), .CHANNELS(4)) i2 ();

  scan_mux #(
    .WIDTH(4), .CHANNELS(4), .DIVIDE(4),
    .GUARD(1), .ACTIVE_LOW_EN(1)
  ) u0 (.clk(clk), .reset(r0), .bus(i0.slave));

  scan_mux #(
    .WIDTH(4), .CHANNELS(3), .DIVIDE(4),
    .GUARD(1), .ACTIVE_LOW_EN(1)
  ) u1 (.clk(clk), .reset(r1), .bus(i1.slave));

  scan_mux #(
    .WIDTH(4), .CHANNELS(4), .DIVIDE(4),
    .GUARD(1), .ACTIVE_LOW_EN(0)
  ) u2 (.clk(clk), .reset(r2), .bus(i2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst0();
    r0 = 1'b1;
    step();
    r0 = 1'b0;
  endtask

  task automatic test_reset();
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
    i0.enable = 1'b1; i1.enable = 1'b1; i2.enable = 1'b1;
    i0.in = 16'h4321; i1.in = 12'h321; i2.in = 16'h4321;
    i0.blank = '0; i1.blank = '0; i2.blank = '0;
    step();
    step();
    vectors++;
    if (i0.out !== 4'h0 || i0.sel !== 2'd0 || i0.digit_en !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_u0 got out=%h sel=%0d en=%b exp 0/0/1111",
               i0.out, i0.sel, i0.digit_en);
    end
    vectors++;
    if (i1.out !== 4'h0 || i1.sel !== 2'd0 || i1.digit_en !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_u1 got out=%h sel=%0d en=%b exp 0/0/111",
               i1.out, i1.sel, i1.digit_en);
    end
    vectors++;
    if (i2.out !== 4'h0 || i2.sel !== 2'd0 || i2.digit_en !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_u2 got out=%h sel=%0d en=%b exp 0/0/0000",
               i2.out, i2.sel, i2.digit_en);
    end
  endtask

  task automatic test_basic();
    logic [3:0] eo, ee;
    logic [1:0] es;
    i0.in = 16'h4321; i0.blank = '0; i0.enable = 1'b1;
    rst0();
    for (int k = 1; k <= 20; k++) begin
      int c, p;
      step();
      c  = ((k - 1) / 4) % 4;
      p  = (k - 1) % 4;
      es = 2'(c);
      eo = 4'(c + 1);
      ee = (p == 0) ? 4'hF : ~(4'b0001 << c);
      vectors++;
      if (i0.out !== eo || i0.sel !== es || i0.digit_en !== ee) begin
        miscompares++;
        $display("FAIL basic k=%0d got %h/%0d/%b exp %h/%0d/%b",
                 k, i0.out, i0.sel, i0.digit_en, eo, es, ee);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] eo;
    logic [2:0] ee;
    logic [1:0] es;
    i1.in = 12'h321; i1.blank = '0; i1.enable = 1'b1;
    r1 = 1'b1;
    step();
    r1 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      int c, p;
      step();
      c  = ((k - 1) / 4) % 3;
      p  = (k - 1) % 4;
      es = 2'(c);
      eo = 4'(c + 1);
      ee = (p == 0) ? 3'b111 : ~(3'b001 << c);
      vectors++;
      if (i1.out !== eo || i1.sel !== es || i1.digit_en !== ee) begin
        miscompares++;
        $display("FAIL wrap k=%0d got %h/%0d/%b exp %h/%0d/%b",
                 k, i1.out, i1.sel, i1.digit_en, eo, es, ee);
      end
    end
  endtask

  task automatic test_blanking();
    logic [3:0] eo, ee;
    i0.in = 16'h4321; i0.blank = 4'b0100; i0.enable = 1'b1;
    rst0();
    for (int k = 1; k <= 16; k++) begin
      int c, p;
      step();
      c  = ((k - 1) / 4) % 4;
      p  = (k - 1) % 4;
      eo = 4'(c + 1);
      ee = (p == 0 || c == 2) ? 4'hF : ~(4'b0001 << c);
      vectors++;
      if (i0.out !== eo || i0.sel !== 2'(c) || i0.digit_en !== ee) begin
        miscompares++;
        $display("FAIL blank k=%0d got %h/%0d/%b exp %h/%0d/%b",
                 k, i0.out, i0.sel, i0.digit_en, eo, c, ee);
      end
    end
    i0.blank = '0;
  endtask

  task automatic test_freeze();
    i0.in = 16'h4321; i0.blank = '0; i0.enable = 1'b1;
    rst0();
    for (int k = 1; k <= 7; k++) step();
    vectors++;
    if (i0.sel !== 2'd1 || i0.digit_en !== 4'b1101) begin
      miscompares++;
      $display("FAIL freeze_pre got sel=%0d en=%b exp 1/1101",
               i0.sel, i0.digit_en);
    end
    i0.enable = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      vectors++;
      if (i0.out !== 4'h2 || i0.sel !== 2'd1 || i0.digit_en !== 4'hF) begin
        miscompares++;
        $display("FAIL freeze_hold n=%0d got %h/%0d/%b exp 2/1/1111",
                 n, i0.out, i0.sel, i0.digit_en);
      end
    end
    i0.enable = 1'b1;
    step();
    vectors++;
    if (i0.out !== 4'h2 || i0.sel !== 2'd1 || i0.digit_en !== 4'b1101) begin
      miscompares++;
      $display("FAIL freeze_resume got %h/%0d/%b exp 2/1/1101",
               i0.out, i0.sel, i0.digit_en);
    end
    step();
    vectors++;
    if (i0.out !== 4'h3 || i0.sel !== 2'd2 || i0.digit_en !== 4'hF) begin
      miscompares++;
      $display("FAIL freeze_guard got %h/%0d/%b exp 3/2/1111",
               i0.out, i0.sel, i0.digit_en);
    end
    for (int n = 0; n < 3; n++) begin
      step();
      vectors++;
      if (i0.out !== 4'h3 || i0.sel !== 2'd2 || i0.digit_en !== 4'b1011) begin
        miscompares++;
        $display("FAIL freeze_ch2 n=%0d got %h/%0d/%b exp 3/2/1011",
                 n, i0.out, i0.sel, i0.digit_en);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ee;
    i0.in = 16'h4321; i0.blank = '0; i0.enable = 1'b1;
    rst0();
    for (int k = 1; k <= 9; k++) step();
    vectors++;
    if (i0.sel !== 2'd2) begin
      miscompares++;
      $display("FAIL rmid_pre got sel=%0d exp 2", i0.sel);
    end
    r0 = 1'b1;
    step();
    r0 = 1'b0;
    vectors++;
    if (i0.out !== 4'h0 || i0.sel !== 2'd0 || i0.digit_en !== 4'hF) begin
      miscompares++;
      $display("FAIL rmid_reset got %h/%0d/%b exp 0/0/1111",
               i0.out, i0.sel, i0.digit_en);
    end
    for (int k = 1; k <= 5; k++) begin
      int c, p;
      step();
      c  = (k - 1) / 4;
      p  = (k - 1) % 4;
      ee = (p == 0) ? 4'hF : ~(4'b0001 << c);
      vectors++;
      if (i0.out !== 4'(c + 1) || i0.sel !== 2'(c) || i0.digit_en !== ee) begin
        miscompares++;
        $display("FAIL rmid_restart k=%0d got %h/%0d/%b exp %0d/%0d/%b",
                 k, i0.out, i0.sel, i0.digit_en, c + 1, c, ee);
      end
    end
  endtask

  task automatic test_live();
    i0.in = 16'h4321; i0.blank = '0; i0.enable = 1'b1;
    rst0();
    step();
    step();
    i0.in = 16'h4329;
    step();
    vectors++;
    if (i0.out !== 4'h9 || i0.digit_en !== 4'b1110) begin
      miscompares++;
      $display("FAIL live got out=%h en=%b exp 9/1110",
               i0.out, i0.digit_en);
    end
    i0.in = 16'h4321;
  endtask

  task automatic test_polarity();
    logic [3:0] ee;
    i2.in = 16'h4321; i2.blank = '0; i2.enable = 1'b1;
    r2 = 1'b1;
    step();
    r2 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      int c, p;
      step();
      c  = ((k - 1) / 4) % 4;
      p  = (k - 1) % 4;
      ee = (p == 0) ? 4'h0 : (4'b0001 << c);
      vectors++;
      if (i2.out !== 4'(c + 1) || i2.sel !== 2'(c) || i2.digit_en !== ee) begin
        miscompares++;
        $display("FAIL polarity k=%0d got %h/%0d/%b exp %0d/%0d/%b",
                 k, i2.out, i2.sel, i2.digit_en, c + 1, c, ee);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_blanking();
    test_freeze();
    test_reset_mid();
    test_live();
    test_polarity();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
